// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_pkg
// Description : Shared UART constants used by the receiver, the transmitter
//               and the receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

    // Width of one UART character as stored in the buffers
    localparam int UART_DATA_W     = 8;

    // Default receive FIFO depth in entries (power of two)
    localparam int UART_FIFO_DEPTH = 16;

    // Returns 1 when the argument is a power of two no smaller than 2
    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage : uart_rx_fifo_pkg
`default_nettype wire

// File: rtl/fifo_regfile.sv
`default_nettype none
// ============================================================================
// Module      : fifo_regfile
// Description : DEPTH x DATA_W register file with one synchronous write port
//               and one combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_regfile
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store the incoming byte at the write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port is a plain mux so the head entry falls through immediately
    assign rd_data = r_mem[rd_addr];

endmodule : fifo_regfile
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive FIFO behind the UART
//               receiver. Keeps pointers, an explicit occupancy count and a
//               sticky overflow flag; storage lives in fifo_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  C_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_push_drop;

    // Flags come from the count register, never from pointer comparison
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_CNT_FULL);

    // A pop on a full FIFO frees the slot the concurrent push needs.
    // A pop on an empty FIFO is simply ignored.
    assign w_pop_ok    = pop  && !w_empty;
    assign w_push_ok   = push && (!w_full || pop);
    assign w_push_drop = push && w_full && !pop;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a dropped push wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    fifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (w_push_ok),
        .wr_addr (r_wr_ptr),
        .wr_data (push_data),
        .rd_addr (r_rd_ptr),
        .rd_data (pop_data)
    );

    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A queue-based model
//               predicts acceptance, occupancy and overflow; a monitor
//               compares every consumed byte against the expected queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              empty;
    logic              full;
    logic [4:0]        count;
    logic              overflow;
    logic              ovf_clr;

    // Scoreboard: bytes the FIFO holds, oldest first
    logic [DATA_W-1:0] exp_q[$];
    int                m_count;
    bit                m_ovf;
    int                n_checks;
    int                n_pass;

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: whenever the consumer pops a non-empty FIFO, the byte it sees
    // must be the oldest one the model still holds.
    always @(negedge clk) begin
        if (rst && pop && !empty) begin
            if (exp_q.size() == 0) begin
                check("pop_on_model_empty", 32'(count), 32'd0);
            end else begin
                check("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(input string tag);
        check({tag, ":count"},    32'(count),    32'(m_count));
        check({tag, ":empty"},    32'(empty),    32'(m_count == 0));
        check({tag, ":full"},     32'(full),     32'(m_count == DEPTH));
        check({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        if (m_count > 0 && exp_q.size() > 0) begin
            check({tag, ":head"}, 32'(pop_data), 32'(exp_q[0]));
        end
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the edge
    task automatic step(input bit p, input logic [7:0] d, input bit q, input bit c, input string tag);
        bit acc_push;
        bit acc_pop;
        bit drop;
        push      = p;
        push_data = d;
        pop       = q;
        ovf_clr   = c;
        acc_pop  = q && (m_count > 0);
        acc_push = p && ((m_count < DEPTH) || q);
        drop     = p && (m_count == DEPTH) && !q;
        @(posedge clk);
        #1;
        m_count = m_count + int'(acc_push) - int'(acc_pop);
        if (acc_push) exp_q.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_clr = 1'b0;
        check_state(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        m_count   = 0;
        m_ovf     = 1'b0;
        rst       = 1'b0;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b1;

        // Two bytes in, two bytes out
        step(1, 8'h55, 0, 0, "t1_push55");
        step(1, 8'hA3, 0, 0, "t1_pushA3");
        step(0, 8'h00, 1, 0, "t1_pop1");
        step(0, 8'h00, 1, 0, "t1_pop2");
        check("t1_drained_count", 32'(count), 32'd0);

        // Fill, overflow, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, "t2_fill");
        step(1, 8'hFF, 0, 0, "t2_overflow");
        check("t2_overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, "t2_drain");

        // Simultaneous push/pop while full; then set-over-clear priority
        step(0, 8'h00, 0, 1, "t3_clr");
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom_range(0, 255)), 0, 0, "t3_fill");
        step(1, 8'h77, 1, 0, "t3_push_pop_full");
        check("t3_count_16", 32'(count), 32'd16);
        check("t3_no_ovf", 32'(overflow), 32'd0);
        step(1, 8'hEE, 0, 1, "t3_set_beats_clr");
        check("t3_ovf_kept", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, "t3_drain");

        // Pop on empty is ignored; a following push falls through at once
        step(0, 8'h00, 1, 0, "t4_pop_empty");
        step(1, 8'h3C, 0, 0, "t4_push3C");
        check("t4_fwft", 32'(pop_data), 32'h3C);
        step(1, 8'h4D, 1, 0, "t4_push_pop");
        step(0, 8'h00, 1, 0, "t4_pop");
        step(1, 8'h5A, 1, 0, "t4_both_on_empty");
        check("t4_both_count", 32'(count), 32'd1);
        step(0, 8'h00, 1, 0, "t4_pop_last");

        // Random interleaved traffic crossing the pointer wrap many times
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 5), "rand");
        end
        while (m_count > 0) step(0, 8'h00, 1, 0, "rand_drain");

        // Asynchronous reset with 5 entries and overflow pending
        for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(8'h80 + i), 0, 0, "t6_fill");
        for (int i = 0; i < DEPTH - 5; i++) step(0, 8'h00, 1, 0, "t6_pop");
        check("t6_pre_count", 32'(count), 32'd5);
        check("t6_pre_ovf", 32'(overflow), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_empty", 32'(empty), 32'd1);
        check("t6_async_count", 32'(count), 32'd0);
        check("t6_async_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 8'h9E, 0, 0, "t6_push9E");
        check("t6_head_9E", 32'(pop_data), 32'h9E);
        step(0, 8'h00, 1, 0, "t6_pop9E");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of stored entries.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push  input  1  one-cycle write strobe; driven by the UART receiver's done pulse.
REQ-006 SHALL have port push_data  input  DATA_W  byte to store; driven by the UART receiver's data output.
REQ-007 SHALL have port pop  input  1  consumer read strobe; removes the head entry.
REQ-008 SHALL have port pop_data  output  DATA_W  head entry, first-word-fall-through.
REQ-009 SHALL have port empty  output  1  high when count is 0.
REQ-010 SHALL have port full  output  1  high when count equals DEPTH.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port overflow  output  1  sticky flag; a push was dropped.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL write push_data at the write pointer and increment the write pointer on a rising clk edge with push=1 and full=0.
REQ-015 SHALL advance the read pointer on a rising clk edge with pop=1 and empty=0.
REQ-016 SHALL drive pop_data combinationally from the storage at the read pointer; a byte pushed at edge N is visible on pop_data after edge N when the FIFO was empty.
REQ-017 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-018 SHALL hold count as a register: +1 on push only, -1 on pop only, unchanged on both or neither; derive empty and full from count.
REQ-019 SHALL ignore pop when empty=1: no pointer or count change and no error flag.
REQ-020 SHALL drop push when full=1 and pop=0: storage, pointers and count unchanged; overflow set to 1 at that edge.
REQ-021 SHALL accept both strobes when full=1 and pop=1 together: pop the head, write the new byte; count stays DEPTH; overflow not set.
REQ-022 SHALL accept push and ignore pop when empty=1 and both strobes are asserted: count becomes 1.
REQ-023 SHALL give set priority over clear when ovf_clr and an overflow-causing push occur in the same cycle: overflow stays 1.
REQ-024 SHALL hold pop_data undefined-but-stable (last storage value at read pointer) while empty=1; consumers qualify it with empty.

Reset
REQ-025 SHALL, while rst=0, force read pointer, write pointer and count to 0 and overflow to 0, giving empty=1 and full=0 immediately and asynchronously.
REQ-026 SHALL not reset the storage array; its contents are unspecified after reset.
REQ-027 SHALL discard all buffered bytes and any in-flight push when reset is asserted mid-operation; the first push after release lands at index 0.

Structure
REQ-028 SHALL place the default DATA_W and DEPTH constants in the shared UART package used by the receiver and transmitter.
REQ-029 SHALL instantiate one sub-module, fifo_regfile: DEPTH x DATA_W storage with one synchronous write port and one combinational read port; all pointer, count and flag logic SHALL stay in uart_rx_fifo.

Verification
REQ-030 SHALL test: push 0x55, then 0xA3 on successive cycles, then pop twice -> pop_data 0x55, then 0xA3; empty=1 and count=0 after the second pop.
REQ-031 SHALL test: push 16 bytes 0x00..0x0F, then push 0xFF -> full=1, count=16, overflow=1; draining all entries returns 0x00..0x0F in order (0xFF absent).
REQ-032 SHALL test: with full=1, assert push=1 (0x77) and pop=1 in the same cycle -> count stays 16, overflow=0, and 0x77 is the last byte drained.
REQ-033 SHALL test: pop with empty=1 -> count stays 0, pointers unchanged; a following push 0x3C appears on pop_data one edge later.
REQ-034 SHALL test: 40 interleaved push/pop cycles crossing the pointer wrap -> output order matches a reference queue; count never exceeds 16.
REQ-035 SHALL test: assert rst=0 with count=5 and overflow=1 -> empty=1, count=0 and overflow=0 without a clock edge; after release, push 0x9E then pop -> 0x9E.
